fft_frame_streamer: RTL and testbench

- Consumer end of the parallel FFT datapath.
- Captures one 64-point result vector (N words of WORD_W bits, presented on one wide bus for one cycle) into a frame buffer.
- Streams the frame out one word per beat on a valid/ready stream interface, with index and last-beat markers.
- Turns the wide, backpressure-free pipeline output into a narrow stream for downstream logic. Frames arriving while busy are dropped and flagged.

---
 rtl/fft_frame_streamer.sv | 61 ++++++
 tb/tb_fft_frame_streamer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer: captures one parallel FFT frame and streams it one word per beat.
// Define FFT_STREAM_BITREV_EN to read the buffer in bit-reversed order (natural-order output).
module fft_frame_streamer #(
    parameter int N_POINTS = 64,
    parameter int WORD_W   = 32,
    parameter int IDX_W    = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_POINTS*WORD_W-1:0] frame_in,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    output logic [WORD_W-1:0]          m_data,
    output logic [IDX_W-1:0]           m_index,
    output logic                       m_valid,
    output logic                       m_last,
    input  logic                       m_ready,
    output logic                       busy,
    output logic                       overflow
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t                     state;
    logic [IDX_W-1:0]           cnt;
    logic [IDX_W-1:0]           sel_idx;
    logic [N_POINTS*WORD_W-1:0] frame_buf;
    logic                       accept;
`ifdef FFT_STREAM_BITREV_EN
    always_comb begin
        sel_idx = '0;
        for (int b = 0; b < IDX_W; b++) sel_idx[b] = cnt[IDX_W-1-b];
    end
`else
    assign sel_idx = cnt;
`endif
    assign m_valid     = (state == STREAM);
    assign busy        = m_valid;
    assign m_index     = cnt;
    assign m_last      = m_valid && (cnt == IDX_W'(N_POINTS - 1));
    assign m_data      = frame_buf[sel_idx*WORD_W +: WORD_W];
    // the only combinational path from m_ready: a new frame may load as the last beat leaves
    assign frame_ready = !m_valid || (m_ready && m_last);
    assign accept      = frame_valid && frame_ready;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_buf <= '0;
            overflow  <= 1'b0;
        end else begin
            if (frame_valid && !frame_ready) overflow <= 1'b1;
            if (accept) begin
                frame_buf <= frame_in;
                cnt       <= '0;
                state     <= STREAM;
            end else if (m_valid && m_ready) begin
                cnt   <= m_last ? '0 : cnt + IDX_W'(1);
                state <= m_last ? IDLE : STREAM;
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb_fft_frame_streamer: directed tests of capture, streaming, backpressure, chaining and drops.
module tb_fft_frame_streamer;
    localparam int N = 64;
    localparam int W = 32;
    localparam int I = 6;
    localparam logic [W-1:0] A = 32'hA000_0000;
    localparam logic [W-1:0] B = 32'hB000_0000;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N*W-1:0] frame_in = '0;
    logic           frame_valid = 1'b0;
    logic           frame_ready;
    logic [W-1:0]   m_data;
    logic [I-1:0]   m_index;
    logic           m_valid;
    logic           m_last;
    logic           m_ready = 1'b0;
    logic           busy;
    logic           overflow;
    int n_cmp = 0;
    int n_err = 0;

    fft_frame_streamer #(.N_POINTS(N), .WORD_W(W), .IDX_W(I)) dut (
        .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .m_data(m_data), .m_index(m_index), .m_valid(m_valid),
        .m_last(m_last), .m_ready(m_ready), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] make_frame(input logic [W-1:0] base);
        logic [N*W-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = base + W'(i);
        return f;
    endfunction

    // buffer word expected on beat i
    function automatic int sel(input int i);
        int r;
`ifdef FFT_STREAM_BITREV_EN
        r = 0;
        for (int b = 0; b < I; b++) if (((i >> b) & 1) != 0) r |= 1 << (I - 1 - b);
`else
        r = i;
`endif
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        frame_valid = 1'b1;
        frame_in = make_frame(A);
        tick;
        tick;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_hold_m_valid got %0b want 0", m_valid); end
        reset = 1'b0;
        frame_valid = 1'b0;
        #1;
        n_cmp++;
        if ({m_valid, m_last, m_index, m_data} !== '0) begin
            n_err++; $display("FAIL reset_outputs got v=%0b l=%0b i=%0d d=%h want all 0", m_valid, m_last, m_index, m_data);
        end
        n_cmp++;
        if ({busy, overflow, frame_ready} !== 3'b001) begin
            n_err++; $display("FAIL reset_flags got busy=%0b ovf=%0b rdy=%0b want 0 0 1", busy, overflow, frame_ready);
        end
        tick;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_beat got %0b want 0", m_valid); end
    endtask

    task automatic test_single;
        frame_in = make_frame(A);
        frame_valid = 1'b1;
        m_ready = 1'b1;
        tick;
        frame_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if ({m_valid, m_last, m_index, m_data} !== {1'b1, i == N - 1, I'(i), A + W'(sel(i))}) begin
                n_err++;
                $display("FAIL single_beat%0d got v=%0b l=%0b i=%0d d=%h want v=1 l=%0b i=%0d d=%h",
                         i, m_valid, m_last, m_index, m_data, i == N - 1, i, A + W'(sel(i)));
            end
            tick;
        end
        n_cmp++;
        if ({m_valid, busy, frame_ready} !== 3'b001) begin
            n_err++; $display("FAIL single_idle got v=%0b busy=%0b rdy=%0b want 0 0 1", m_valid, busy, frame_ready);
        end
    endtask

    task automatic test_backpressure;
        int e = 0;
        int lasts = 0;
        int c = 0;
        frame_in = make_frame(A);
        frame_valid = 1'b1;
        m_ready = 1'b0;
        tick;
        frame_valid = 1'b0;
        while (e < N && c < 400) begin
            m_ready = (c % 4 == 0) || (c % 4 == 3);
            n_cmp++;
            if ({m_valid, m_last, m_index, m_data} !== {1'b1, e == N - 1, I'(e), A + W'(sel(e))}) begin
                n_err++;
                $display("FAIL bp_cycle%0d got v=%0b l=%0b i=%0d d=%h want v=1 l=%0b i=%0d d=%h",
                         c, m_valid, m_last, m_index, m_data, e == N - 1, e, A + W'(sel(e)));
            end
            if (m_ready) begin
                if (m_last) lasts++;
                e++;
            end
            c++;
            tick;
        end
        m_ready = 1'b0;
        n_cmp++;
        if (e != N) begin n_err++; $display("FAIL bp_timeout got %0d beats want %0d", e, N); end
        n_cmp++;
        if (lasts != 1) begin n_err++; $display("FAIL bp_last_count got %0d want 1", lasts); end
        n_cmp++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle got %0b want 0", m_valid); end
    endtask

    task automatic test_back_to_back;
        frame_in = make_frame(A);
        frame_valid = 1'b1;
        m_ready = 1'b1;
        tick;
        frame_valid = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            n_cmp++;
            if ({m_valid, m_index, m_data} !== {1'b1, I'(i), A + W'(sel(i))}) begin
                n_err++; $display("FAIL b2b_a%0d got i=%0d d=%h want i=%0d d=%h", i, m_index, m_data, i, A + W'(sel(i)));
            end
            tick;
        end
        n_cmp++;
        if ({m_last, frame_ready} !== 2'b11) begin
            n_err++; $display("FAIL b2b_end got last=%0b rdy=%0b want 1 1", m_last, frame_ready);
        end
        frame_in = make_frame(B);
        frame_valid = 1'b1;
        tick;
        frame_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if ({m_valid, m_last, m_index, m_data} !== {1'b1, i == N - 1, I'(i), B + W'(sel(i))}) begin
                n_err++;
                $display("FAIL b2b_b%0d got v=%0b l=%0b i=%0d d=%h want v=1 l=%0b i=%0d d=%h",
                         i, m_valid, m_last, m_index, m_data, i == N - 1, i, B + W'(sel(i)));
            end
            tick;
        end
        n_cmp++;
        if ({m_valid, overflow} !== 2'b00) begin
            n_err++; $display("FAIL b2b_after got v=%0b ovf=%0b want 0 0", m_valid, overflow);
        end
    endtask

    task automatic test_drop;
        frame_in = make_frame(A);
        frame_valid = 1'b1;
        m_ready = 1'b1;
        tick;
        frame_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        m_ready = 1'b0;
        frame_in = make_frame(B);
        frame_valid = 1'b1;
        #1;
        n_cmp++;
        if (frame_ready !== 1'b0) begin n_err++; $display("FAIL drop_ready got %0b want 0", frame_ready); end
        tick;
        frame_valid = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL drop_overflow got %0b want 1", overflow); end
        m_ready = 1'b1;
        for (int i = 10; i < N; i++) begin
            n_cmp++;
            if ({m_valid, m_last, m_index, m_data} !== {1'b1, i == N - 1, I'(i), A + W'(sel(i))}) begin
                n_err++;
                $display("FAIL drop_beat%0d got v=%0b l=%0b i=%0d d=%h want v=1 l=%0b i=%0d d=%h",
                         i, m_valid, m_last, m_index, m_data, i == N - 1, i, A + W'(sel(i)));
            end
            tick;
        end
        n_cmp++;
        if ({m_valid, overflow} !== 2'b01) begin
            n_err++; $display("FAIL drop_after got v=%0b ovf=%0b want 0 1", m_valid, overflow);
        end
        frame_in = make_frame(A);
        frame_valid = 1'b1;
        tick;
        frame_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick;
        n_cmp++;
        if (m_index !== I'(20)) begin n_err++; $display("FAIL midreset_pre got i=%0d want 20", m_index); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_cmp++;
        if ({m_valid, busy, overflow, m_index} !== {3'b000, I'(0)}) begin
            n_err++; $display("FAIL midreset got v=%0b busy=%0b ovf=%0b i=%0d want 0 0 0 0", m_valid, busy, overflow, m_index);
        end
        tick;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL midreset_quiet got %0b want 0", m_valid); end
        m_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_back_to_back;
        test_drop;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
